uart_rx_monitor: RTL

- Synthesizable UART receiver that consumes the serial line driven by the SoC top's uart_tx pin.
- Deserializes 8N1 frames into bytes and buffers them in a small FIFO.
- Presents bytes on a valid/ready interface to the bench console logger, or to an on-FPGA debug sink.
- Sits directly downstream of the SoC top's UART output, in the same 100 MHz system clock domain.

---
 rtl/uart_mon_pkg.sv | 6 +
 rtl/uart_mon_fifo.sv | 43 ++++
 rtl/uart_rx_monitor.sv | 106 ++++++++++
 3 files changed

// File: rtl/uart_mon_pkg.sv
// uart_mon_pkg: shared receiver state encoding and frame constants
package uart_mon_pkg;
    localparam int UART_DATA_BITS = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
endpackage

// File: rtl/uart_mon_fifo.sv
// uart_mon_fifo: synchronous byte FIFO; a push into a full FIFO is only accepted alongside a pop
module uart_mon_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic                       drop,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop = push && !do_push;
    assign rdata = empty ? '0 : mem[rd_ptr];
    // pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    // storage needs no reset: rdata is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 UART receiver feeding a byte FIFO with valid/ready output and sticky error flags
module uart_rx_monitor
    import uart_mon_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rx_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          busy_o,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    input  logic                          clear_i
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    logic [1:0] sync;
    logic rxs, tick, push, drop, ferr_set, empty, full;
    rx_state_e state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] shreg, sh_n;
    assign rxs = sync[1];
    assign tick = cnt == '0;
    assign busy_o = state != IDLE;
    assign valid_o = !empty;
    // two-flop synchronizer, idling high so reset never looks like a start bit
    always_ff @(posedge clk_i) begin
        sync <= rst_i ? 2'b11 : {sync[0], rx_i};
    end
    // receiver state, bit/clock counters and shift register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt <= '0;
            bit_idx <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bit_idx <= bit_n;
            shreg <= sh_n;
        end
    end
    // next state: every sample lands mid-bit, half a bit after the start edge then whole bits
    always_comb begin
        state_n = state;
        cnt_n = tick ? cnt : cnt - 1'b1;
        bit_n = bit_idx;
        sh_n = shreg;
        push = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE: if (!rxs) begin
                state_n = START;
                cnt_n = HALF;
            end
            START: if (tick) begin
                state_n = rxs ? IDLE : DATA;
                cnt_n = FULL;
                bit_n = '0;
            end
            DATA: if (tick) begin
                sh_n = {rxs, shreg[7:1]};
                cnt_n = FULL;
                bit_n = bit_idx + 1'b1;
                state_n = (bit_idx == 3'(UART_DATA_BITS - 1)) ? STOP : DATA;
            end
            STOP: if (tick) begin
                push = rxs;
                ferr_set = !rxs;
                state_n = rxs ? IDLE : BREAK;
            end
            BREAK: state_n = rxs ? IDLE : BREAK;
            default: state_n = IDLE;
        endcase
    end
    // sticky error flags; a new event in the clearing cycle wins
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_err_o <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            frame_err_o <= ferr_set || (frame_err_o && !clear_i);
            overflow_o <= drop || (overflow_o && !clear_i);
        end
    end
    uart_mon_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
        .clk(clk_i),
        .rst(rst_i),
        .push(push),
        .pop(ready_i),
        .wdata(shreg),
        .rdata(data_o),
        .full(full),
        .empty(empty),
        .drop(drop),
        .count(count_o)
    );
endmodule
